// File: rtl/alu_sec.sv
// alu_sec: sequential ALU front end for board bring-up.
// Operands A, B and a 6-bit function code are captured from shared buses
// by independent level-sensitive load strobes; the result is registered.
//
// Ports:
//   clk     - system clock, all updates on rising edge
//   reset   - synchronous, active-high; clears all registers
//   buf_A   - operand A input bus (msb+1 bits)
//   buf_B   - operand B input bus, also the shift amount (msb+1 bits)
//   buf_Op  - 6-bit function code input bus
//   p_a     - load enable for A register
//   p_b     - load enable for B register
//   p_c     - load enable for Op register
//   buf_R   - registered ALU result (msb+1 bits)
module alu_sec #(
  parameter int msb = 7
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [msb:0]   buf_A,
  input  logic [msb:0]   buf_B,
  input  logic [5:0]     buf_Op,
  input  logic           p_a,
  input  logic           p_b,
  input  logic           p_c,
  output logic [msb:0]   buf_R
);

  typedef enum logic [5:0] {
    OP_SRL = 6'b000010,
    OP_SRA = 6'b000011,
    OP_ADD = 6'b100000,
    OP_SUB = 6'b100010,
    OP_AND = 6'b100100,
    OP_OR  = 6'b100101,
    OP_XOR = 6'b100110,
    OP_NOR = 6'b100111
  } op_e;

  logic [msb:0] A_q;
  logic [msb:0] B_q;
  logic [5:0]   Op_q;
  logic [msb:0] R_q;
  logic [msb:0] r_next;

  // Shift amount is the full unsigned B; shifting by >= width yields
  // zero (logical) or all sign bits (arithmetic) by language semantics.
  always_comb begin
    r_next = '0;
    case (Op_q)
      OP_ADD:  r_next = A_q + B_q;
      OP_SUB:  r_next = A_q - B_q;
      OP_AND:  r_next = A_q & B_q;
      OP_OR:   r_next = A_q | B_q;
      OP_XOR:  r_next = A_q ^ B_q;
      OP_NOR:  r_next = ~(A_q | B_q);
      OP_SRA:  r_next = $unsigned($signed(A_q) >>> B_q);
      OP_SRL:  r_next = A_q >> B_q;
      default: r_next = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      A_q  <= '0;
      B_q  <= '0;
      Op_q <= '0;
      R_q  <= '0;
    end else begin
      if (p_a) A_q  <= buf_A;
      if (p_b) B_q  <= buf_B;
      if (p_c) Op_q <= buf_Op;
      R_q <= r_next;
    end
  end

  assign buf_R = R_q;

endmodule

// File: tb/tb_alu_sec.sv
// Testbench for alu_sec: table of directed load/expect vectors plus
// hand-written sequences for reset, latency and hold behaviour.
module tb_alu_sec;

  localparam logic [5:0] ADD = 6'b100000;
  localparam logic [5:0] SUB = 6'b100010;
  localparam logic [5:0] AND = 6'b100100;
  localparam logic [5:0] OR  = 6'b100101;
  localparam logic [5:0] XOR = 6'b100110;
  localparam logic [5:0] NOR = 6'b100111;
  localparam logic [5:0] SRA = 6'b000011;
  localparam logic [5:0] SRL = 6'b000010;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] buf_A;
  logic [7:0] buf_B;
  logic [5:0] buf_Op;
  logic       p_a;
  logic       p_b;
  logic       p_c;
  logic [7:0] buf_R;

  int n_cmp = 0;
  int n_err = 0;

  alu_sec #(.msb(7)) dut (
    .clk    (clk),
    .reset  (reset),
    .buf_A  (buf_A),
    .buf_B  (buf_B),
    .buf_Op (buf_Op),
    .p_a    (p_a),
    .p_b    (p_b),
    .p_c    (p_c),
    .buf_R  (buf_R)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pa;
    logic       pb;
    logic       pc;
    logic [7:0] a;
    logic [7:0] b;
    logic [5:0] op;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic pa, input logic pb, input logic pc,
                         input logic [7:0] a, input logic [7:0] b,
                         input logic [5:0] op, input logic [7:0] exp);
    vec_t v;
    v.pa = pa; v.pb = pb; v.pc = pc;
    v.a = a; v.b = b; v.op = op; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [7:0] act,
                       input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  logic [7:0] prev;

  initial begin
    reset = 1'b0;
    buf_A = '0; buf_B = '0; buf_Op = '0;
    p_a = 1'b0; p_b = 1'b0; p_c = 1'b0;

    // Reset with nonzero buses and all strobes high
    @(negedge clk);
    reset = 1'b1;
    buf_A = 8'h5A; buf_B = 8'h33; buf_Op = ADD;
    p_a = 1'b1; p_b = 1'b1; p_c = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("reset_R", buf_R, 8'h00);

    // Release reset; load only NOR. All-ones proves A and B were cleared.
    reset = 1'b0;
    p_a = 1'b0; p_b = 1'b0;
    buf_Op = NOR;
    @(negedge clk);
    p_c = 1'b0;
    buf_Op = 6'h00;
    check("lat_old", buf_R, 8'h00);
    @(negedge clk);
    check("lat_new", buf_R, 8'hFF);
    prev = 8'hFF;

    // Vectors: A=0, B=0, Op=NOR at start
    add_vec(1, 0, 0, 8'd20,  8'h00, 6'h00, 8'hEB); // ~(20|0)
    add_vec(0, 1, 0, 8'h00,  8'd7,  6'h00, 8'hE8); // ~(20|7)
    add_vec(0, 0, 1, 8'h00,  8'h00, ADD,   8'd27);
    add_vec(0, 0, 1, 8'h00,  8'h00, SUB,   8'd13);
    add_vec(0, 0, 1, 8'h00,  8'h00, AND,   8'd4);
    add_vec(0, 0, 1, 8'h00,  8'h00, OR,    8'd23);
    add_vec(0, 0, 1, 8'h00,  8'h00, XOR,   8'd19);
    add_vec(0, 0, 1, 8'h00,  8'h00, NOR,   8'hE8);
    add_vec(0, 0, 1, 8'h00,  8'h00, 6'h00, 8'h00);
    add_vec(0, 1, 0, 8'h00,  8'd2,  6'h00, 8'h00);
    add_vec(1, 0, 0, 8'hF4,  8'h00, 6'h00, 8'h00);
    add_vec(0, 0, 1, 8'h00,  8'h00, SRA,   8'hFD);
    add_vec(0, 0, 1, 8'h00,  8'h00, SRL,   8'h3D);
    add_vec(0, 0, 1, 8'h00,  8'h00, NOR,   8'h09);
    add_vec(0, 1, 0, 8'h00,  8'd9,  6'h00, 8'h02); // ~(F4|09), no Op re-strobe
    add_vec(0, 0, 1, 8'h00,  8'h00, SRA,   8'hFF);
    add_vec(0, 0, 1, 8'h00,  8'h00, SRL,   8'h00);
    add_vec(1, 1, 0, 8'hFF,  8'h01, 6'h00, 8'h7F); // SRL FF by 1
    add_vec(0, 0, 1, 8'h00,  8'h00, ADD,   8'h00);
    add_vec(1, 1, 0, 8'h00,  8'h01, 6'h00, 8'h01);
    add_vec(0, 0, 1, 8'h00,  8'h00, SUB,   8'hFF);
    add_vec(1, 1, 1, 8'd3,   8'd5,  ADD,   8'd8);

    foreach (vecs[i]) begin
      buf_A = vecs[i].a; buf_B = vecs[i].b; buf_Op = vecs[i].op;
      p_a = vecs[i].pa; p_b = vecs[i].pb; p_c = vecs[i].pc;
      @(negedge clk);
      // Load edge done: drop strobes and scramble buses, which must not matter
      p_a = 1'b0; p_b = 1'b0; p_c = 1'b0;
      buf_A = ~vecs[i].a; buf_B = ~vecs[i].b; buf_Op = ~vecs[i].op;
      check($sformatf("vec%0d_old", i), buf_R, prev);
      @(negedge clk);
      check($sformatf("vec%0d", i), buf_R, vecs[i].exp);
      prev = vecs[i].exp;
    end

    // Bus changes with strobes low leave the result alone
    buf_A = 8'h00; buf_B = 8'h00; buf_Op = 6'h00;
    repeat (3) @(negedge clk);
    check("hold", buf_R, 8'd8);

    // Mid-sequence reset clears everything at that edge, strobe ignored
    reset = 1'b1;
    buf_A = 8'h11; p_a = 1'b1;
    @(negedge clk);
    check("midreset", buf_R, 8'h00);
    reset = 1'b0; p_a = 1'b0;
    @(negedge clk);
    check("post_reset", buf_R, 8'h00);

    // Strobe held over several cycles reloads same value
    buf_A = 8'h40; buf_B = 8'h04; buf_Op = SRL;
    p_a = 1'b1; p_b = 1'b1; p_c = 1'b1;
    repeat (4) @(negedge clk);
    check("held_strobe", buf_R, 8'h04);
    p_a = 1'b0; p_b = 1'b0; p_c = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
